// File: rtl/level_sweep_stop.sv
// Level sweep source for the thermometer bar decoder: a 4-bit level bounces 0..15..0
// at a prescaled rate, freezes on a stop press (one-cycle en strobe) and resumes on go.
module level_sweep_stop #(
    parameter int unsigned DIV   = 4,
    parameter int unsigned DIV_W = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       stop_btn,
    input  logic       go_btn,
    output logic [3:0] b,
    output logic       en,
    output logic       running,
    output logic       dir
);

    // state | meaning
    // IDLE  | after reset, waiting for the first go press; level parked at 0
    // RUN   | sweeping, one level step every DIV cycles
    // HOLD  | level and direction frozen after a stop press; go resumes
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [DIV_W-1:0] LAST_TICK = DIV_W'(DIV - 1);

    state_t           state, state_next;
    logic [DIV_W-1:0] prescaler, prescaler_next;
    logic [3:0]       b_next;
    logic             dir_next;
    logic             en_pend, en_pend_next;
    logic             stop_q, go_q;
    logic             stop_rise, go_rise;

    assign stop_rise = stop_btn & ~stop_q;
    assign go_rise   = go_btn & ~go_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            b         <= 4'd0;
            dir       <= 1'b1;
            prescaler <= '0;
            en_pend   <= 1'b0;
            en        <= 1'b0;
            running   <= 1'b0;
            stop_q    <= 1'b1;
            go_q      <= 1'b1;
        end else begin
            state     <= state_next;
            b         <= b_next;
            dir       <= dir_next;
            prescaler <= prescaler_next;
            en_pend   <= en_pend_next;
            en        <= en_pend;
            running   <= (state_next == RUN);
            stop_q    <= stop_btn;
            go_q      <= go_btn;
        end
    end

    always_comb begin
        state_next     = state;
        b_next         = b;
        dir_next       = dir;
        prescaler_next = prescaler;
        en_pend_next   = 1'b0;

        case (state)
            IDLE: begin
                if (go_rise) begin
                    state_next     = RUN;
                    b_next         = 4'd0;
                    dir_next       = 1'b1;
                    prescaler_next = '0;
                end
            end
            RUN: begin
                // Stop beats a step due in the same cycle; en follows one cycle
                // after the freeze so b is already stable when it is seen.
                if (stop_rise) begin
                    state_next     = HOLD;
                    prescaler_next = '0;
                    en_pend_next   = 1'b1;
                end else if (prescaler == LAST_TICK) begin
                    prescaler_next = '0;
                    if (dir) begin
                        if (b == 4'd15) begin
                            dir_next = 1'b0;
                            b_next   = 4'd14;
                        end else begin
                            b_next = b + 4'd1;
                        end
                    end else begin
                        if (b == 4'd0) begin
                            dir_next = 1'b1;
                            b_next   = 4'd1;
                        end else begin
                            b_next = b - 4'd1;
                        end
                    end
                end else begin
                    prescaler_next = prescaler + 1'b1;
                end
            end
            HOLD: begin
                if (go_rise) begin
                    state_next     = RUN;
                    prescaler_next = '0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
